pong_lcd_ctrl: RTL and testbench

PONG_LCD_CTRL -- requirements
Module: pong_lcd_ctrl

---
 rtl/pong_lcd_pkg.sv | 24 ++
 rtl/pong_edge_toggle.sv | 19 +
 rtl/pong_lcd_ctrl.sv | 108 ++++++++++
 tb/tb_pong_lcd_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pong_lcd_pkg.sv
// Shared definitions for the Pong HD44780-style LCD write controller:
// state encoding, counter width and the slow clear/home command codes.
package pong_lcd_pkg;

  localparam int CNT_W = 17;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_t;

  // Clear and home are commands only; the same bytes written as data are fast.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
    return !rs && (db == CMD_CLEAR || db == CMD_HOME || db == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/pong_edge_toggle.sv
// Registered change detector: flags any difference between the input level
// and the value it had on the previous clock.
module pong_edge_toggle (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic change
);

  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= level;
  end

  assign change = level ^ prev;

endmodule

// File: rtl/pong_lcd_ctrl.sv
// LCD write sequencer driven by two PIO bytes: a toggle in pio_ctrl[0]
// launches one setup/enable/hold/execute cycle on the parallel LCD bus.
module pong_lcd_ctrl
  import pong_lcd_pkg::*;
#(
  parameter int T_SETUP     = 4,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pio_ctrl,
  input  logic [7:0] pio_data,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic       overrun
);

  lcd_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             start;

  // Only the go toggle and rs bit carry meaning; the rest of the byte is spare.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^pio_ctrl[7:2];

  pong_edge_toggle u_go (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (pio_ctrl[0]),
    .change  (start)
  );

  // The counter is loaded with (duration - 1) on entry so each state lasts
  // exactly its parameter in cycles; bus values are frozen from accept onward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lcd_db  <= 8'h00;
      lcd_rs  <= 1'b0;
      lcd_rw  <= 1'b0;
      lcd_e   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      lcd_rw  <= 1'b0;
      overrun <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            lcd_db <= pio_data;
            lcd_rs <= pio_ctrl[1];
            busy   <= 1'b1;
            cnt    <= CNT_W'(T_SETUP - 1);
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= CNT_W'(T_PW - 1);
            state <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= CNT_W'(T_HOLD - 1);
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long_cmd(lcd_rs, lcd_db) ? CNT_W'(T_EXEC_LONG - 1)
                                                 : CNT_W'(T_EXEC - 1);
            state <= EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          lcd_e <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_lcd_ctrl.sv
// Directed bench for pong_lcd_ctrl: a vector table of writes measured
// cycle by cycle, plus reset and no-retry sequences.
module tb_pong_lcd_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] pio_ctrl;
  logic [7:0] pio_data;
  logic [7:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  pong_lcd_ctrl #(
    .T_SETUP     (2),
    .T_PW        (3),
    .T_HOLD      (2),
    .T_EXEC      (5),
    .T_EXEC_LONG (10)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pio_ctrl (pio_ctrl),
    .pio_data (pio_data),
    .lcd_db   (lcd_db),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         retog_at;
    int         chg_at;
    int         exp_busy;
    int         exp_ovr;
    int         exp_ovr_at;
  } vec_t;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; toggles go and measures the transfer one cycle at a time.
  task automatic apply_stimulus(input logic [7:0] data, input logic rs,
                                input int retog_at, input int chg_at,
                                output int busy_len, output int e_start,
                                output int e_len, output int e_rises,
                                output int bus_bad, output int ovr_cnt,
                                output int ovr_at);
    logic e_prev;
    pio_data = data;
    pio_ctrl = {6'b0, rs, ~pio_ctrl[0]};
    busy_len = 0; e_start = 0; e_len = 0; e_rises = 0;
    bus_bad = 0; ovr_cnt = 0; ovr_at = 0; e_prev = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (overrun) begin
        ovr_cnt++;
        if (ovr_at == 0) ovr_at = n;
      end
      if (lcd_db !== data || lcd_rs !== rs || lcd_rw !== 1'b0) bus_bad++;
      if (lcd_e) begin
        if (e_start == 0) e_start = n;
        e_len++;
        if (!e_prev) e_rises++;
      end
      e_prev = lcd_e;
      if (!busy) break;
      busy_len++;
      if (n == retog_at) pio_ctrl[0] = ~pio_ctrl[0];
      if (n == chg_at) begin
        pio_data = 8'hFF;
        pio_ctrl[1] = ~rs;
      end
    end
  endtask

  vec_t vecs[8];
  int   bl, es, el, er, bb, oc, oa;
  int   cnt_b, cnt_e;

  initial begin
    vecs[0] = '{8'h41, 1'b1, 0,  0, 12, 0, 0};
    vecs[1] = '{8'h01, 1'b0, 0,  0, 17, 0, 0};
    vecs[2] = '{8'h02, 1'b0, 0,  0, 17, 0, 0};
    vecs[3] = '{8'h03, 1'b0, 0,  0, 17, 0, 0};
    vecs[4] = '{8'h01, 1'b1, 0,  0, 12, 0, 0};
    vecs[5] = '{8'h04, 1'b0, 0,  0, 12, 0, 0};
    vecs[6] = '{8'h41, 1'b1, 4,  0, 12, 1, 5};
    vecs[7] = '{8'h55, 1'b1, 0,  4, 12, 0, 0};

    reset_n  = 1'b0;
    pio_ctrl = 8'h00;
    pio_data = 8'h00;
    #12;
    check_output("reset_db", lcd_db, 0);
    check_output("reset_rs", lcd_rs, 0);
    check_output("reset_rw", lcd_rw, 0);
    check_output("reset_e", lcd_e, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_overrun", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("idle_after_reset_busy", busy, 0);

    // Each write is issued on the first idle cycle after the previous one.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].data, vecs[i].rs, vecs[i].retog_at, vecs[i].chg_at,
                     bl, es, el, er, bb, oc, oa);
      check_output($sformatf("v%0d_busy_len", i), bl, vecs[i].exp_busy);
      check_output($sformatf("v%0d_e_start", i), es, 3);
      check_output($sformatf("v%0d_e_len", i), el, 3);
      check_output($sformatf("v%0d_e_pulses", i), er, 1);
      check_output($sformatf("v%0d_bus_bad_cycles", i), bb, 0);
      check_output($sformatf("v%0d_overrun_count", i), oc, vecs[i].exp_ovr);
      if (vecs[i].exp_ovr != 0)
        check_output($sformatf("v%0d_overrun_cycle", i), oa, vecs[i].exp_ovr_at);
    end

    // Toggle in the last EXEC cycle is dropped and never retried.
    apply_stimulus(8'h30, 1'b1, 12, 0, bl, es, el, er, bb, oc, oa);
    check_output("late_toggle_busy_len", bl, 12);
    check_output("late_toggle_overrun_count", oc, 1);
    check_output("late_toggle_overrun_cycle", oa, 13);
    cnt_b = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (busy) cnt_b++;
    end
    check_output("no_retry_busy_cycles", cnt_b, 0);

    // Reset asserted while lcd_e is high.
    pio_data = 8'h41;
    pio_ctrl = {6'b0, 1'b1, ~pio_ctrl[0]};
    for (int n = 0; n < 3; n++) @(negedge clk);
    check_output("pre_reset_e_high", lcd_e, 1);
    reset_n = 1'b0;
    #1;
    check_output("midreset_e", lcd_e, 0);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_db", lcd_db, 0);
    check_output("midreset_rs", lcd_rs, 0);
    check_output("midreset_overrun", overrun, 0);
    pio_ctrl = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    cnt_b = 0;
    cnt_e = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy) cnt_b++;
      if (lcd_e) cnt_e++;
    end
    check_output("release_low_busy_cycles", cnt_b, 0);
    check_output("release_low_e_cycles", cnt_e, 0);

    // Releasing reset with go already high counts as a toggle.
    reset_n  = 1'b0;
    pio_data = 8'h02;
    pio_ctrl = 8'h01;
    @(negedge clk);
    reset_n = 1'b1;
    cnt_b = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) break;
      cnt_b++;
    end
    check_output("release_high_busy_len", cnt_b, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
